// File: rtl/idct_dezigzag_dequant.sv
// rtl/idct_dezigzag_dequant.sv - zigzag coefficient dequantiser and row-major ping-pong reorder buffer
module idct_dezigzag_dequant #(
    parameter int COEF_W = 16,
    parameter int QT_W   = 8,
    parameter int OUT_W  = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 qt_wen,
    input  logic [5:0]           qt_addr,
    input  logic [QT_W-1:0]      qt_wdata,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COEF_W-1:0]    in_coef,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_row,
    output logic                 out_last,
    output logic [8*OUT_W-1:0]   out_data
);

    localparam int PW = COEF_W + QT_W + 1;

    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [QT_W-1:0]  qt  [64];
    logic [OUT_W-1:0] mem [2][64];
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic             wr_sel;
    logic             rd_sel;
    logic [5:0]       k;
    logic             in_fire;
    logic             out_fire;
    logic             blk_done;
    logic             row_done;
    logic [PW-1:0]    coef_x;
    logic [PW-1:0]    qt_x;
    logic [PW-1:0]    prod;
    logic [OUT_W-1:0] prod_ext;

    assign in_ready  = !full[wr_sel];
    assign out_valid = full[rd_sel];
    assign out_last  = out_valid && (out_row == 3'd7);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign blk_done  = in_fire && (k == 6'd63);
    assign row_done  = out_fire && (out_row == 3'd7);

    // Qt entry is zero-extended so it multiplies as a non-negative signed value;
    // the full-width product cannot overflow, so no saturation is needed.
    assign coef_x   = {{(QT_W+1){in_coef[COEF_W-1]}}, in_coef};
    assign qt_x     = {{(COEF_W+1){1'b0}}, qt[k]};
    assign prod     = coef_x * qt_x;
    assign prod_ext = {{(OUT_W-PW){prod[PW-1]}}, prod};

    // Fill and drain always target different buffers, so both flag updates can land together.
    always_comb begin
        full_next = full;
        if (blk_done) full_next[wr_sel] = 1'b1;
        if (row_done) full_next[rd_sel] = 1'b0;
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int c = 0; c < 8; c++) begin
                out_data[c*OUT_W +: OUT_W] = mem[rd_sel][{out_row, 3'(c)}];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 64; i++) qt[i] <= QT_W'(1);
        end else if (qt_wen) begin
            qt[qt_addr] <= qt_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem[wr_sel][ZZ[k]] <= prod_ext;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full    <= 2'b00;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            k       <= 6'd0;
            out_row <= 3'd0;
        end else begin
            full <= full_next;
            if (in_fire) begin
                k <= k + 6'd1;
                if (blk_done) wr_sel <= ~wr_sel;
            end
            if (out_fire) begin
                out_row <= out_row + 3'd1;
                if (row_done) rd_sel <= ~rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_idct_dezigzag_dequant.sv
// tb/tb_idct_dezigzag_dequant.sv - randomized self-checking bench against a block-level queue model
module tb_idct_dezigzag_dequant;

    typedef logic [31:0] blk_t  [64];
    typedef logic [15:0] cblk_t [64];

    logic         clk = 1'b0;
    logic         resetn;
    logic         qt_wen;
    logic [5:0]   qt_addr;
    logic [7:0]   qt_wdata;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_coef;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_row;
    logic         out_last;
    logic [255:0] out_data;

    idct_dezigzag_dequant dut (
        .clk      (clk),
        .resetn   (resetn),
        .qt_wen   (qt_wen),
        .qt_addr  (qt_addr),
        .qt_wdata (qt_wdata),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_coef  (in_coef),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_last (out_last),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           nat [64];
    int           qt_m [64];
    int           kk;
    int           rrow;
    int           rows_out;
    blk_t         cur;
    blk_t         blocks [$];
    logic [255:0] seen [8];
    logic         obs_ir;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) qt_m[i] = 1;
        kk = 0;
        rrow = 0;
        blocks.delete();
    endtask

    // One clock: drive at negedge, compare against the model, advance the model across the edge.
    task automatic cycle(input logic iv, input logic [15:0] coef, input logic orr,
                         input logic qw, input logic [5:0] qa, input logic [7:0] qd,
                         output logic acc);
        logic         exp_ir;
        logic [255:0] exp_row;
        int           p;
        in_valid = iv; in_coef = coef; out_ready = orr;
        qt_wen = qw; qt_addr = qa; qt_wdata = qd;
        #1;
        exp_ir = (blocks.size() < 2);
        obs_ir = in_ready;
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, blocks.size() > 0);
        if (blocks.size() > 0) begin
            for (int c = 0; c < 8; c++) exp_row[c*32 +: 32] = blocks[0][rrow*8 + c];
            check("out_data", out_data, exp_row);
            check("out_row", out_row, rrow);
            check("out_last", out_last, rrow == 7);
        end else begin
            check("out_last_idle", out_last, 0);
        end
        acc = iv && exp_ir;
        if (orr && blocks.size() > 0) begin
            seen[rrow] = out_data;
            rows_out++;
            if (rrow == 7) begin
                void'(blocks.pop_front());
                rrow = 0;
            end else begin
                rrow++;
            end
        end
        if (acc) begin
            p = int'($signed(coef)) * qt_m[kk];
            cur[nat[kk]] = p;
            kk++;
            if (kk == 64) begin
                blocks.push_back(cur);
                kk = 0;
            end
        end
        if (qw) qt_m[qa] = int'(qd);
        @(negedge clk);
    endtask

    task automatic feed(input cblk_t blk, input logic orr);
        int   i = 0;
        int   guard = 0;
        logic acc;
        while (i < 64 && guard < 1000) begin
            cycle(1'b1, blk[i], orr, 1'b0, 6'd0, 8'd0, acc);
            if (acc) i++;
            guard++;
        end
        if (i < 64) check("feed_timeout", i, 64);
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 1'b1, 1'b0, 6'd0, 8'd0, acc);
    endtask

    task automatic do_reset();
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; qt_wen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        model_reset();
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_out_row", out_row, 0);
    endtask

    initial begin
        cblk_t        blk;
        logic         acc;
        logic [255:0] exp_v;
        int           r0 [8];
        int           r1 [8];
        int           idx;
        int           cnt;
        int           first_high;
        int           rows_before;

        idx = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin nat[idx] = r*8 + (s - r); idx++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin nat[idx] = r*8 + (s - r); idx++; end
            end
        end
        for (int i = 0; i < 64; i++) cur[i] = '0;
        rows_out = 0;
        in_coef = '0; qt_addr = '0; qt_wdata = '0;
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; qt_wen = 1'b0;
        @(negedge clk);
        do_reset();

        // DC only
        for (int i = 0; i < 64; i++) blk[i] = 16'd0;
        blk[0] = 16'd100;
        feed(blk, 1'b1);
        drain(12);
        check("dc_row0", seen[0], 256'd100);
        check("dc_row7", seen[7], 256'd0);

        // Reorder
        for (int i = 0; i < 64; i++) blk[i] = 16'(i + 1);
        feed(blk, 1'b1);
        drain(12);
        r0 = '{1, 2, 6, 7, 15, 16, 28, 29};
        r1 = '{3, 5, 8, 14, 17, 27, 30, 43};
        for (int c = 0; c < 8; c++) exp_v[c*32 +: 32] = r0[c];
        check("reorder_row0", seen[0], exp_v);
        for (int c = 0; c < 8; c++) exp_v[c*32 +: 32] = r1[c];
        check("reorder_row1", seen[1], exp_v);
        check("reorder_r7w7", seen[7][255:224], 64);

        // Dequant sign
        cycle(1'b0, 16'd0, 1'b1, 1'b1, 6'd0, 8'd255, acc);
        cycle(1'b0, 16'd0, 1'b1, 1'b1, 6'd1, 8'd2, acc);
        for (int i = 0; i < 64; i++) blk[i] = 16'($urandom);
        blk[0] = 16'h8000;
        blk[1] = 16'hFFFD;
        feed(blk, 1'b1);
        drain(12);
        check("sign_w0", seen[0][31:0], 32'hFF808000);
        check("sign_w1", seen[0][63:32], 32'hFFFFFFFA);

        // Ping-pong backpressure
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 6'd0, 8'd0, acc);
            if (acc) cnt++;
        end
        check("bp_accepts", cnt, 128);
        check("bp_in_ready_low", in_ready, 0);
        first_high = -1;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 6'd0, 8'd0, acc);
            if (first_high < 0 && obs_ir) first_high = i;
        end
        check("bp_ready_return", first_high, 8);
        drain(30);

        // Reset mid-block
        cnt = 0;
        while (cnt < 30) begin
            cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 6'd0, 8'd0, acc);
            if (acc) cnt++;
        end
        do_reset();
        rows_before = rows_out;
        for (int i = 0; i < 64; i++) blk[i] = 16'($urandom);
        feed(blk, 1'b1);
        drain(12);
        check("midrst_rows", rows_out - rows_before, 8);

        // Random traffic with table rewrites
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom),
                  (i % 400 < 150) ? 1'b0 : ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 15) == 0, 6'($urandom), 8'($urandom), acc);
        end
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
